// File: rtl/seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// seq_shift_add_multiplier
//   Unsigned sequential shift-and-add multiplier, the MUL partner of the
//   shift-subtract divider. The {acc, q} register pair shifts right one bit per
//   cycle. The captured multiplicand is added into acc whenever the current
//   LSB of q is set. One result is produced every WIDTH+2 cycles at most.
//
// Ports
//   clock        : single clock; all state updates on the rising edge
//   rst          : synchronous, active-high reset (overrides everything)
//   start        : operation request. It is only looked at while idle.
//   multiplicand : operand M, captured when start is accepted
//   multiplier   : operand Q, captured when start is accepted
//   busy         : high while the WIDTH iterations are running
//   done         : one-cycle pulse; product is valid from this cycle on
//   product      : registered 2*WIDTH-bit result, held until the next result
//
// WIDTH must be at least 2.
// ---------------------------------------------------------------------------
module seq_shift_add_multiplier #(
    parameter int WIDTH = 10
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state_reg,   state_next;
    logic [WIDTH-1:0]   acc_reg,     acc_next;
    logic [WIDTH-1:0]   q_reg,       q_next;
    logic [WIDTH-1:0]   m_reg,       m_next;
    logic [CW-1:0]      count_reg,   count_next;
    logic [2*WIDTH-1:0] product_reg, product_next;

    // Partial product for this iteration: M gated by the current LSB of q.
    logic [WIDTH-1:0]   addend;
    // One extra bit so the carry out of acc + M is kept and shifted into acc.
    logic [WIDTH:0]     sum;
    logic               last_iter;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_addend
            assign addend[gi] = m_reg[gi] & q_reg[0];
        end
    endgenerate

    assign sum       = {1'b0, acc_reg} + {1'b0, addend};
    assign last_iter = (count_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        q_next       = q_reg;
        m_next       = m_reg;
        count_next   = count_reg;
        product_next = product_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                    acc_next   = '0;
                    q_next     = multiplier;
                    m_next     = multiplicand;
                    count_next = '0;
                end
            end
            CALC: begin
                // Shift the full (WIDTH+1)-bit sum right into {acc, q}; the
                // bit of q just consumed falls off the bottom.
                acc_next   = sum[WIDTH:1];
                q_next     = {sum[0], q_reg[WIDTH-1:1]};
                count_next = count_reg + CW'(1);
                if (last_iter) begin
                    state_next   = DONE;
                    // Same value {acc, q} takes at this edge, published here.
                    product_next = {sum, q_reg[WIDTH-1:1]};
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            count_reg   <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            q_reg       <= q_next;
            m_reg       <= m_next;
            count_reg   <= count_next;
            product_reg <= product_next;
        end
    end

    assign busy    = (state_reg == CALC);
    assign done    = (state_reg == DONE);
    assign product = product_reg;

endmodule
